// File: rtl/mem_arb.sv
// mem_arb: shares one memory port between IFU and LSU, one transaction in flight.
// Define MEM_ARB_RR_EN for round-robin ties; otherwise the LSU has fixed priority.
module mem_arb #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ifu_req_valid,
   output logic                      ifu_req_ready,
   input  logic [ADDR_WIDTH-1:0]     ifu_addr,
   output logic                      ifu_resp_valid,
   output logic [DATA_WIDTH-1:0]     ifu_resp_data,
   input  logic                      lsu_req_valid,
   output logic                      lsu_req_ready,
   input  logic [ADDR_WIDTH-1:0]     lsu_addr,
   input  logic                      lsu_wen,
   input  logic [DATA_WIDTH-1:0]     lsu_wdata,
   input  logic [DATA_WIDTH/8-1:0]   lsu_wmask,
   output logic                      lsu_resp_valid,
   output logic [DATA_WIDTH-1:0]     lsu_resp_data,
   output logic                      mem_req_valid,
   input  logic                      mem_req_ready,
   output logic [ADDR_WIDTH-1:0]     mem_addr,
   output logic                      mem_wen,
   output logic [DATA_WIDTH-1:0]     mem_wdata,
   output logic [DATA_WIDTH/8-1:0]   mem_wmask,
   input  logic                      mem_resp_valid,
   input  logic [DATA_WIDTH-1:0]     mem_resp_data,
   output logic                      spurious
);

   localparam int MASK_W = DATA_WIDTH / 8;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]            state_q, state_d;
   logic                  owner_q, owner_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  wen_q, wen_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [MASK_W-1:0]     wmask_q, wmask_d;
   logic                  ifu_rv_q, ifu_rv_d;
   logic                  lsu_rv_q, lsu_rv_d;
   logic [DATA_WIDTH-1:0] ifu_rd_q, ifu_rd_d;
   logic [DATA_WIDTH-1:0] lsu_rd_q, lsu_rd_d;
   logic                  spurious_q, spurious_d;
   logic                  gnt_ifu, gnt_lsu, idle;

`ifdef MEM_ARB_RR_EN
   // 1 = LSU owned the most recently accepted request
   logic                  last_owner_q, last_owner_d;

   always_comb begin
      gnt_ifu = ifu_req_valid;
      gnt_lsu = lsu_req_valid;
      if (ifu_req_valid && lsu_req_valid) begin
         gnt_ifu = last_owner_q;
         gnt_lsu = !last_owner_q;
      end
   end
`else
   always_comb begin
      gnt_lsu = lsu_req_valid;
      gnt_ifu = ifu_req_valid && !lsu_req_valid;
   end
`endif

   assign idle          = (state_q == S_IDLE);
   assign ifu_req_ready = idle && gnt_ifu;
   assign lsu_req_ready = idle && gnt_lsu;

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      addr_d     = addr_q;
      wen_d      = wen_q;
      wdata_d    = wdata_q;
      wmask_d    = wmask_q;
      ifu_rv_d   = 1'b0;
      lsu_rv_d   = 1'b0;
      ifu_rd_d   = ifu_rd_q;
      lsu_rd_d   = lsu_rd_q;
      spurious_d = spurious_q | (mem_resp_valid && state_q != S_RESP);
`ifdef MEM_ARB_RR_EN
      last_owner_d = last_owner_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (gnt_lsu) begin
               state_d = S_REQ;
               owner_d = 1'b1;
               addr_d  = lsu_addr;
               wen_d   = lsu_wen;
               wdata_d = lsu_wdata;
               wmask_d = lsu_wmask;
`ifdef MEM_ARB_RR_EN
               last_owner_d = 1'b1;
`endif
            end else if (gnt_ifu) begin
               state_d = S_REQ;
               owner_d = 1'b0;
               addr_d  = ifu_addr;
               wen_d   = 1'b0;
               wdata_d = '0;
               wmask_d = '0;
`ifdef MEM_ARB_RR_EN
               last_owner_d = 1'b0;
`endif
            end
         end
         S_REQ: begin
            if (mem_req_ready) state_d = S_RESP;
         end
         S_RESP: begin
            if (mem_resp_valid) begin
               state_d = S_IDLE;
               if (owner_q) begin
                  lsu_rv_d = 1'b1;
                  lsu_rd_d = wen_q ? '0 : mem_resp_data;
               end else begin
                  ifu_rv_d = 1'b1;
                  ifu_rd_d = mem_resp_data;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         owner_q    <= 1'b0;
         addr_q     <= '0;
         wen_q      <= 1'b0;
         wdata_q    <= '0;
         wmask_q    <= '0;
         ifu_rv_q   <= 1'b0;
         lsu_rv_q   <= 1'b0;
         ifu_rd_q   <= '0;
         lsu_rd_q   <= '0;
         spurious_q <= 1'b0;
`ifdef MEM_ARB_RR_EN
         last_owner_q <= 1'b1;
`endif
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         addr_q     <= addr_d;
         wen_q      <= wen_d;
         wdata_q    <= wdata_d;
         wmask_q    <= wmask_d;
         ifu_rv_q   <= ifu_rv_d;
         lsu_rv_q   <= lsu_rv_d;
         ifu_rd_q   <= ifu_rd_d;
         lsu_rd_q   <= lsu_rd_d;
         spurious_q <= spurious_d;
`ifdef MEM_ARB_RR_EN
         last_owner_q <= last_owner_d;
`endif
      end
   end

   assign mem_req_valid  = (state_q == S_REQ);
   assign mem_addr       = addr_q;
   assign mem_wen        = wen_q;
   assign mem_wdata      = wdata_q;
   assign mem_wmask      = wmask_q;
   assign ifu_resp_valid = ifu_rv_q;
   assign lsu_resp_valid = lsu_rv_q;
   assign ifu_resp_data  = ifu_rd_q;
   assign lsu_resp_data  = lsu_rd_q;
   assign spurious       = spurious_q;

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: grant table, directed transactions, abort case, random traffic.
// The tie-break expectation follows MEM_ARB_RR_EN the same way the design does.
module tb_mem_arb;

   logic        clk;
   logic        rst;
   logic        ifu_req_valid, ifu_req_ready;
   logic [31:0] ifu_addr;
   logic        ifu_resp_valid;
   logic [31:0] ifu_resp_data;
   logic        lsu_req_valid, lsu_req_ready;
   logic [31:0] lsu_addr;
   logic        lsu_wen;
   logic [31:0] lsu_wdata;
   logic [3:0]  lsu_wmask;
   logic        lsu_resp_valid;
   logic [31:0] lsu_resp_data;
   logic        mem_req_valid, mem_req_ready;
   logic [31:0] mem_addr;
   logic        mem_wen;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        spurious;

   int total = 0;
   int passed = 0;

`ifdef MEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   mem_arb #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
      .ifu_addr(ifu_addr),
      .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
      .lsu_addr(lsu_addr), .lsu_wen(lsu_wen),
      .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
      .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_addr(mem_addr), .mem_wen(mem_wen),
      .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .spurious(spurious)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   task automatic chk1(input string nm, input logic act, input logic exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else passed++;
   endtask

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else passed++;
   endtask

   function automatic logic rb();
      logic [31:0] r;
      r = $urandom;
      return r[0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      ifu_req_valid = 0; ifu_addr = 0;
      lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0;
      lsu_wdata = 0; lsu_wmask = 0;
      mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1;
      repeat (2) tick();
      chk1("rst mem_req_valid", mem_req_valid, 1'b0);
      chk1("rst ifu_resp_valid", ifu_resp_valid, 1'b0);
      chk1("rst lsu_resp_valid", lsu_resp_valid, 1'b0);
      chk1("rst ifu_req_ready", ifu_req_ready, 1'b0);
      chk1("rst lsu_req_ready", lsu_req_ready, 1'b0);
      chk1("rst spurious", spurious, 1'b0);
      chk1("rst mem_wen", mem_wen, 1'b0);
      chk32("rst mem_addr", mem_addr, 32'h0);
      chk32("rst mem_wdata", mem_wdata, 32'h0);
      chk32("rst mem_wmask", {28'h0, mem_wmask}, 32'h0);
      chk32("rst ifu_resp_data", ifu_resp_data, 32'h0);
      chk32("rst lsu_resp_data", lsu_resp_data, 32'h0);
      rst = 0;
   endtask

   // One complete transaction from an idle arbiter; exp_l selects the expected winner.
   task automatic do_txn(input logic iv, input logic lv, input logic exp_l,
                         input logic [31:0] ia, input logic [31:0] la,
                         input logic lw, input logic [31:0] lwd,
                         input logic [3:0] lm, input logic [31:0] rd,
                         input int stall, input string tag);
      logic [31:0] ea, ed;
      logic        ew;
      logic [3:0]  em;
      ea = exp_l ? la : ia;
      ew = exp_l & lw;
      em = exp_l ? lm : 4'h0;
      ed = (exp_l && lw) ? 32'h0 : rd;
      ifu_req_valid = iv; ifu_addr = ia;
      lsu_req_valid = lv; lsu_addr = la; lsu_wen = lw;
      lsu_wdata = lwd; lsu_wmask = lm;
      #1;
      chk1({tag, " ifu_req_ready"}, ifu_req_ready, !exp_l);
      chk1({tag, " lsu_req_ready"}, lsu_req_ready, exp_l);
      tick();
      ifu_req_valid = 0; lsu_req_valid = 0;
      ifu_addr = ~ia; lsu_addr = ~la; lsu_wdata = ~lwd;
      lsu_wmask = ~lm; lsu_wen = !lw;
      for (int k = 0; k < stall; k++) begin
         ifu_req_valid = 1; lsu_req_valid = 1; mem_req_ready = 0;
         #1;
         chk1({tag, " stall mem_req_valid"}, mem_req_valid, 1'b1);
         chk32({tag, " stall mem_addr"}, mem_addr, ea);
         chk1({tag, " stall mem_wen"}, mem_wen, ew);
         chk32({tag, " stall mem_wmask"}, {28'h0, mem_wmask}, {28'h0, em});
         chk1({tag, " stall ifu_req_ready"}, ifu_req_ready, 1'b0);
         chk1({tag, " stall lsu_req_ready"}, lsu_req_ready, 1'b0);
         tick();
      end
      ifu_req_valid = 0; lsu_req_valid = 0; mem_req_ready = 1;
      #1;
      chk1({tag, " mem_req_valid"}, mem_req_valid, 1'b1);
      chk32({tag, " mem_addr"}, mem_addr, ea);
      chk1({tag, " mem_wen"}, mem_wen, ew);
      chk32({tag, " mem_wmask"}, {28'h0, mem_wmask}, {28'h0, em});
      if (exp_l) chk32({tag, " mem_wdata"}, mem_wdata, lwd);
      tick();
      mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = rd;
      #1;
      chk1({tag, " resp-state mem_req_valid"}, mem_req_valid, 1'b0);
      chk1({tag, " early ifu_resp_valid"}, ifu_resp_valid, 1'b0);
      chk1({tag, " early lsu_resp_valid"}, lsu_resp_valid, 1'b0);
      tick();
      mem_resp_valid = 0; mem_resp_data = 32'h0bad0bad;
      #1;
      chk1({tag, " ifu_resp_valid"}, ifu_resp_valid, !exp_l);
      chk1({tag, " lsu_resp_valid"}, lsu_resp_valid, exp_l);
      if (exp_l) chk32({tag, " lsu_resp_data"}, lsu_resp_data, ed);
      else chk32({tag, " ifu_resp_data"}, ifu_resp_data, ed);
      tick();
      chk1({tag, " post ifu_resp_valid"}, ifu_resp_valid, 1'b0);
      chk1({tag, " post lsu_resp_valid"}, lsu_resp_valid, 1'b0);
   endtask

   typedef struct {
      logic ifu_v;
      logic lsu_v;
      logic exp_ifu_rdy;
      logic exp_lsu_rdy;
   } vec_t;

   initial begin
      vec_t vecs[4];
      logic exp_l;
      bit   pend, issued, last_lsu;
      bit   ep_i, ep_l, w_i, w_l;
      logic [31:0] c_addr, c_wdata, ep_d;
      logic        c_wen, c_own;
      logic [3:0]  c_mask;
      logic [31:0] r;

      vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1};
      vecs[3] = '{1'b1, 1'b1, RR, !RR};

      do_reset();

      // Combinational grant in IDLE; no clock edge passes while these are applied.
      for (int i = 0; i < 4; i++) begin
         ifu_req_valid = vecs[i].ifu_v;
         lsu_req_valid = vecs[i].lsu_v;
         #1;
         chk1($sformatf("vec%0d ifu_req_ready", i), ifu_req_ready, vecs[i].exp_ifu_rdy);
         chk1($sformatf("vec%0d lsu_req_ready", i), lsu_req_ready, vecs[i].exp_lsu_rdy);
      end
      ifu_req_valid = 0; lsu_req_valid = 0;
      tick();

      do_txn(1, 0, 0, 32'h80000000, 32'h0, 0, 32'h0, 4'h0,
             32'h00000413, 0, "ifu_read");
      do_txn(0, 1, 1, 32'h0, 32'h80001000, 1, 32'hDEADBEEF, 4'b0011,
             32'h12345678, 0, "lsu_store");

      for (int rnd = 0; rnd < 4; rnd++) begin
         exp_l = RR ? logic'(rnd % 2 == 1) : 1'b1;
         do_txn(1, 1, exp_l, 32'h80000100 + rnd, 32'h80002000 + rnd, 0,
                32'h0, 4'hF, 32'hA0000000 + rnd, 0, $sformatf("tie%0d", rnd));
      end

      do_txn(0, 1, 1, 32'h0, 32'h80003000, 0, 32'h0, 4'hF,
             32'hCAFEF00D, 5, "backpressure");

      // Abort in RESP, then a late response two cycles after rst.
      ifu_req_valid = 1; ifu_addr = 32'h80000040;
      tick();
      ifu_req_valid = 0; mem_req_ready = 1;
      tick();
      mem_req_ready = 0; rst = 1;
      tick();
      rst = 0;
      #1;
      chk1("abort ifu_resp_valid", ifu_resp_valid, 1'b0);
      chk1("abort lsu_resp_valid", lsu_resp_valid, 1'b0);
      chk1("abort mem_req_valid", mem_req_valid, 1'b0);
      chk1("abort spurious pre", spurious, 1'b0);
      tick();
      mem_resp_valid = 1; mem_resp_data = 32'h55555555;
      tick();
      mem_resp_valid = 0;
      #1;
      chk1("late spurious", spurious, 1'b1);
      chk1("late ifu_resp_valid", ifu_resp_valid, 1'b0);
      chk1("late lsu_resp_valid", lsu_resp_valid, 1'b0);
      do_txn(1, 0, 0, 32'h80000044, 32'h0, 0, 32'h0, 4'h0,
             32'h00100073, 0, "after_abort");
      chk1("spurious sticky", spurious, 1'b1);

      // Random traffic against a transaction-level model.
      do_reset();
      pend = 0; issued = 0; last_lsu = 1; ep_i = 0; ep_l = 0; ep_d = 0;
      c_addr = 0; c_wdata = 0; c_wen = 0; c_own = 0; c_mask = 0;
      for (int c = 0; c < 600; c++) begin
         chk1("rand ifu_resp_valid", ifu_resp_valid, ep_i);
         chk1("rand lsu_resp_valid", lsu_resp_valid, ep_l);
         if (ep_i) chk32("rand ifu_resp_data", ifu_resp_data, ep_d);
         if (ep_l) chk32("rand lsu_resp_data", lsu_resp_data, ep_d);
         ifu_req_valid = rb(); ifu_addr = $urandom;
         lsu_req_valid = rb(); lsu_addr = $urandom; lsu_wen = rb();
         lsu_wdata = $urandom;
         r = $urandom; lsu_wmask = r[3:0];
         mem_req_ready = rb() | rb();
         mem_resp_valid = issued && rb();
         mem_resp_data = $urandom;
         w_i = 0; w_l = 0;
         if (!pend) begin
            if (RR && ifu_req_valid && lsu_req_valid) begin
               w_i = last_lsu; w_l = !last_lsu;
            end else begin
               w_l = lsu_req_valid;
               w_i = ifu_req_valid && !lsu_req_valid;
            end
         end
         #1;
         chk1("rand ifu_req_ready", ifu_req_ready, w_i);
         chk1("rand lsu_req_ready", lsu_req_ready, w_l);
         chk1("rand mem_req_valid", mem_req_valid, pend && !issued);
         if (pend && !issued) begin
            chk32("rand mem_addr", mem_addr, c_addr);
            chk1("rand mem_wen", mem_wen, c_wen);
            chk32("rand mem_wmask", {28'h0, mem_wmask}, {28'h0, c_mask});
            if (c_own) chk32("rand mem_wdata", mem_wdata, c_wdata);
         end
         ep_i = 0; ep_l = 0;
         if (w_i || w_l) begin
            pend = 1; issued = 0; c_own = w_l;
            c_addr = w_l ? lsu_addr : ifu_addr;
            c_wen = w_l & lsu_wen;
            c_wdata = lsu_wdata;
            c_mask = w_l ? lsu_wmask : 4'h0;
            last_lsu = w_l;
         end else if (pend && !issued && mem_req_ready) begin
            issued = 1;
         end else if (issued && mem_resp_valid) begin
            pend = 0; issued = 0;
            ep_i = !c_own; ep_l = c_own;
            ep_d = c_wen ? 32'h0 : mem_resp_data;
         end
         tick();
      end
      chk1("rand spurious", spurious, 1'b0);
      clear_inputs();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
